imem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_array.sv | 29 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
`default_nettype none

package imem_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] FILL_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    DONE    = 2'd3
  } imem_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// imem_array: 2^ADDR_W x 16 register file, one synchronous write, one async read.
`default_nettype none

module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: byte-wide program loader and combinational fetch port that
// holds the processor in reset until a complete image has been received.
`default_nettype none

`ifndef BITNESS
`define BITNESS 16
`endif

module imem_loader
  import imem_pkg::*;
#(
  parameter int                PC_W   = `BITNESS,
  parameter int                ADDR_W = 8,
  parameter logic [WORD_W-1:0] FILL   = FILL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc,
  output logic [WORD_W-1:0] instruction,
  output logic              cpu_rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [BYTE_W-1:0] ld_byte,
  input  logic              ld_last,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  localparam int CMP_W = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;

  imem_state_t       state, state_n;
  logic [BYTE_W-1:0] lo;
  logic              accept;
  logic              full;
  logic              start_take;
  logic              we;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic [CMP_W-1:0]  pc_ext;
  logic [CMP_W-1:0]  wc_ext;

  assign accept     = ld_valid && ld_ready;
  // The count saturates at exactly 2^ADDR_W, so its top bit marks a full array.
  assign full       = word_count[ADDR_W];
  assign start_take = ld_start && (state == IDLE || state == DONE);

  always_comb begin
    state_n = state;
    we      = 1'b0;
    wdata   = {{BYTE_W{1'b0}}, ld_byte};
    case (state)
      IDLE, DONE: begin
        if (ld_start) state_n = LOAD_LO;
      end
      LOAD_LO: begin
        if (accept) begin
          if (ld_last) begin
            we      = !full;
            state_n = DONE;
          end else begin
            state_n = LOAD_HI;
          end
        end
      end
      LOAD_HI: begin
        if (accept) begin
          we      = !full;
          wdata   = {ld_byte, lo};
          state_n = ld_last ? DONE : LOAD_LO;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst    <= 1'b1;
      ld_ready   <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
      lo         <= '0;
    end else begin
      state    <= state_n;
      cpu_rst  <= (state_n != DONE);
      ld_ready <= (state_n == LOAD_LO) || (state_n == LOAD_HI);
      if (state == LOAD_LO && accept) lo <= ld_byte;
      if (start_take) begin
        word_count <= '0;
        err        <= 1'b0;
      end else begin
        if (we) word_count <= word_count + (ADDR_W + 1)'(1);
        if (accept && (full || (state == LOAD_LO && ld_last))) err <= 1'b1;
      end
    end
  end

  assign loaded = (state == DONE);

  imem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (word_count[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (ADDR_W'(pc)),
    .rdata (rdata)
  );

  // Stale array contents from earlier images stay hidden behind the count.
  assign pc_ext      = CMP_W'(pc);
  assign wc_ext      = CMP_W'(word_count);
  assign instruction = (pc_ext < wc_ext) ? rdata : FILL;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized checks against a byte-queue model.
`default_nettype none

module tb_imem_loader;

  localparam int PC_W   = 16;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PC_W-1:0]   pc = '0;
  logic [15:0]       instruction;
  logic              cpu_rst;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [7:0]        ld_byte = '0;
  logic              ld_last = 1'b0;
  logic              loaded;
  logic [ADDR_W:0]   word_count;
  logic              err;

  always #5 clk = ~clk;

  imem_loader #(
    .PC_W   (PC_W),
    .ADDR_W (ADDR_W),
    .FILL   (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instruction (instruction),
    .cpu_rst     (cpu_rst),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .loaded      (loaded),
    .word_count  (word_count),
    .err         (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the current image is simply the list of bytes accepted since start.
  logic [7:0] img[$];
  bit m_loading = 1'b0;
  bit m_done    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
      img.delete();
    end else if (!m_loading) begin
      if (ld_start) begin
        m_loading = 1'b1;
        m_done    = 1'b0;
        img.delete();
      end
    end else if (ld_valid) begin
      img.push_back(ld_byte);
      if (ld_last) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
      end
    end
  end

  function automatic int m_wc();
    int n = img.size();
    int w = n / 2 + ((m_done && (n % 2 == 1)) ? 1 : 0);
    return (w > DEPTH) ? DEPTH : w;
  endfunction

  function automatic logic m_err();
    return (img.size() > 2 * DEPTH) || (m_done && (img.size() % 2 == 1));
  endfunction

  function automatic logic [15:0] m_instr(input int addr);
    logic [7:0] lo_b;
    logic [7:0] hi_b;
    if (addr >= m_wc()) return 16'h0000;
    lo_b = img[2 * addr];
    hi_b = (2 * addr + 1 < img.size()) ? img[2 * addr + 1] : 8'h00;
    return {hi_b, lo_b};
  endfunction

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("cpu_rst",     32'(cpu_rst),     32'(!m_done));
      chk("ld_ready",    32'(ld_ready),    32'(m_loading));
      chk("loaded",      32'(loaded),      32'(m_done));
      chk("word_count",  32'(word_count),  32'(m_wc()));
      chk("err",         32'(err),         32'(m_err()));
      chk("instruction", 32'(instruction), 32'(m_instr(int'(pc))));
    end
  end

  // Inputs are applied for exactly one edge, then returned to idle.
  task automatic step(input logic s, input logic v, input logic [7:0] b, input logic l);
    @(negedge clk);
    ld_start = s;
    ld_valid = v;
    ld_byte  = b;
    ld_last  = l;
    @(posedge clk);
    #3;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pcchk(input string name, input logic [PC_W-1:0] addr, input logic [15:0] exp);
    pc = addr;
    #1;
    chk(name, 32'(instruction), 32'(exp));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst_cpu_rst",  32'(cpu_rst), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_wc",       32'(word_count), 32'd0);
    pcchk("rst_pc0", 16'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Two-word image
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("start_ready", 32'(ld_ready), 32'd1);
    step(1'b0, 1'b1, 8'h34, 1'b0);
    step(1'b0, 1'b1, 8'h12, 1'b0);
    step(1'b0, 1'b1, 8'hCD, 1'b0);
    step(1'b0, 1'b1, 8'hAB, 1'b1);
    chk("img_wc",      32'(word_count), 32'd2);
    chk("img_loaded",  32'(loaded), 32'd1);
    chk("img_cpu_rst", 32'(cpu_rst), 32'd0);
    pcchk("img_pc0", 16'd0, 16'h1234);
    pcchk("img_pc1", 16'd1, 16'hABCD);
    pcchk("img_pc2", 16'd2, 16'h0000);
    pcchk("img_pc_hi", 16'h0100, 16'h0000);

    // Odd-length image
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b1);
    pcchk("odd_pc0", 16'd0, 16'h7755);
    pcchk("odd_pc1", 16'd1, 16'h0099);
    chk("odd_err",    32'(err), 32'd1);
    chk("odd_loaded", 32'(loaded), 32'd1);

    // Reload from DONE with a byte offered in the start cycle
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("rel_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rel_wc",      32'(word_count), 32'd0);
    chk("rel_err",     32'(err), 32'd0);
    pcchk("rel_pc0", 16'd0, 16'h0000);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b1);
    pcchk("rel_word", 16'd0, 16'h0201);

    // Overflow: 10 bytes into a 4-word array
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 8'(i), (i == 10));
    chk("ovf_wc",  32'(word_count), 32'd4);
    chk("ovf_err", 32'(err), 32'd1);
    pcchk("ovf_pc0", 16'd0, 16'h0201);
    pcchk("ovf_pc3", 16'd3, 16'h0807);

    // Reset while waiting for a high byte
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk("mrst_wc",      32'(word_count), 32'd0);
    chk("mrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mrst_ready",   32'(ld_ready), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h0A, 1'b0);
    step(1'b0, 1'b1, 8'h0B, 1'b1);
    pcchk("mrst_word", 16'd0, 16'h0B0A);
    chk("mrst_loaded", 32'(loaded), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      ld_start = ($urandom_range(0, 14) == 0);
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_byte  = 8'($urandom);
      ld_last  = ($urandom_range(0, 9) == 0);
      pc       = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
    end
    @(negedge clk);
    rst      = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
